// File: rtl/add_seq_ctrl.sv
// ============================================================================
// add_seq_ctrl : nibble-serial W-bit add/subtract built on the 4-bit adder add
// Rev 1.0
// ============================================================================
`default_nettype none

module add (
   input  logic [3:0] num1,
   input  logic [3:0] num2,
   output logic [3:0] Resul,
   output logic       Cout
);

   logic [4:0] w_c;

   assign w_c[0] = 1'b0;

   for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      assign Resul[gi]  = num1[gi] ^ num2[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (num1[gi] & num2[gi]) | (w_c[gi] & (num1[gi] ^ num2[gi]));
   end

   assign Cout = w_c[4];

endmodule

module add_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   sub,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout
);

   localparam int                W      = 4 * NIBBLES;
   localparam int                IDXW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0]   C_LAST = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [W-1:0]      r_a_sh;
   logic [W-1:0]      r_b_sh;
   logic              r_carry;
   logic [IDXW-1:0]   r_idx;
   logic [W-1:0]      r_result;
   logic              r_cout;
   logic              r_busy;
   logic              r_done;

   logic [3:0]        w_sum0;
   logic              w_c0;
   logic [3:0]        w_nib;
   logic              w_c1;
   logic              w_nib_c;

   // Carry-in is added by a second adder; both carries can never be set together.
   add u_add0 (
      .num1  (r_a_sh[3:0]),
      .num2  (r_b_sh[3:0]),
      .Resul (w_sum0),
      .Cout  (w_c0)
   );

   add u_add1 (
      .num1  (w_sum0),
      .num2  ({3'b000, r_carry}),
      .Resul (w_nib),
      .Cout  (w_c1)
   );

   assign w_nib_c = w_c0 | w_c1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a_sh  <= op_a;
                  r_b_sh  <= sub ? ~op_b : op_b;
                  r_carry <= sub;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               for (int n = 0; n < NIBBLES; n++) begin
                  if (r_idx == IDXW'(n)) begin
                     r_result[4*n +: 4] <= w_nib;
                  end
               end
               r_a_sh  <= r_a_sh >> 4;
               r_b_sh  <= r_b_sh >> 4;
               r_carry <= w_nib_c;
               r_idx   <= r_idx + 1'b1;
               if (r_idx == C_LAST) begin
                  r_cout  <= w_nib_c;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign cout   = r_cout;

endmodule

`default_nettype wire
